// File: rtl/byte_unstriping_n_pkg.sv
// byte_unstriping_n_pkg: shared lane-count/width defaults and clog2 helper for the striping stages
package byte_unstriping_n_pkg;
  localparam int LANES_DEFAULT = 4;
  localparam int LANE_W_DEFAULT = 8;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/byte_unstriping_n_lane_fifo.sv
// lane_fifo: single-clock sync FIFO; a push into a full FIFO is taken when it pops the same cycle
module lane_fifo
  import byte_unstriping_n_pkg::*;
#(
  parameter int DATA_WIDTH = LANE_W_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = clog2(FIFO_DEPTH);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic do_push, do_pop;
  assign full  = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign empty = cnt_q == '0;
  assign rdata = mem_q[rd_q];
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = wdata;
    wr_d  = do_push ? wr_q + 1'b1 : wr_q;
    rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/byte_unstriping_n.sv
// byte_unstriping_n: merges per-lane FIFOs into one lane-ordered stream via a non-skipping round-robin pointer
module byte_unstriping_n
  import byte_unstriping_n_pkg::*;
#(
  parameter int NUM_LANES  = LANES_DEFAULT,
  parameter int DATA_WIDTH = LANE_W_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] LANE_DATA,
  input  logic [NUM_LANES-1:0]            LANE_VALID,
  output logic [DATA_WIDTH-1:0]           DATA_OUT,
  output logic                            VALID_OUT,
  output logic [clog2(NUM_LANES)-1:0]     LANE_SEL,
  output logic [NUM_LANES-1:0]            OVERFLOW
);
  localparam int SW = clog2(NUM_LANES);
  logic [SW-1:0] rr_q, rr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic [NUM_LANES-1:0] ovf_q, ovf_d, pop, full, empty;
  logic [DATA_WIDTH-1:0] rdata [NUM_LANES];
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk  (CLK),
      .rst  (RESET),
      .push (LANE_VALID[i]),
      .pop  (pop[i]),
      .wdata(LANE_DATA[i*DATA_WIDTH +: DATA_WIDTH]),
      .rdata(rdata[i]),
      .full (full[i]),
      .empty(empty[i])
    );
  end
  always_comb begin
    pop = '0;
    pop[rr_q] = !empty[rr_q];
    valid_d = !empty[rr_q];
    data_d  = valid_d ? rdata[rr_q] : data_q;
    rr_d    = !valid_d ? rr_q : rr_q == SW'(NUM_LANES-1) ? '0 : rr_q + 1'b1;
    ovf_d   = ovf_q | (LANE_VALID & full & ~pop);
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= '0;
    end else begin
      rr_q    <= rr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end
  assign DATA_OUT  = data_q;
  assign VALID_OUT = valid_q;
  assign LANE_SEL  = rr_q;
  assign OVERFLOW  = ovf_q;
endmodule

// File: tb/tb_byte_unstriping_n.sv
// tb_byte_unstriping_n: scoreboard bench; per-lane queues of sent words define the interleaved output order
module tb_byte_unstriping_n;
  logic clk, rst;
  logic [31:0] lane_data;
  logic [3:0] lane_valid, ovf;
  logic [7:0] data_out;
  logic valid_out;
  logic [1:0] lane_sel;
  logic [47:0] l1_data;
  logic [2:0] l1_valid, ovf1;
  logic [15:0] out1;
  logic v1;
  logic [1:0] sel1;
  int tests = 0;
  int fails = 0;
  int k = 0;
  logic [7:0] lq [4][$];
  byte_unstriping_n u0 (
    .CLK(clk), .RESET(rst), .LANE_DATA(lane_data), .LANE_VALID(lane_valid),
    .DATA_OUT(data_out), .VALID_OUT(valid_out), .LANE_SEL(lane_sel), .OVERFLOW(ovf)
  );
  byte_unstriping_n #(.NUM_LANES(3), .DATA_WIDTH(16), .FIFO_DEPTH(4)) u1 (
    .CLK(clk), .RESET(rst), .LANE_DATA(l1_data), .LANE_VALID(l1_valid),
    .DATA_OUT(out1), .VALID_OUT(v1), .LANE_SEL(sel1), .OVERFLOW(ovf1)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask
  // lane-order model: output n is the next word sent on lane n mod 4
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) lq[i].delete();
      k = 0;
    end else if (valid_out) begin
      tests++;
      if (lq[k % 4].size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected got %0h expected none (lane %0d)", data_out, k % 4);
      end else begin
        logic [7:0] e;
        e = lq[k % 4].pop_front();
        if (data_out !== e) begin
          fails++;
          $display("FAIL sb_data got %0h expected %0h", data_out, e);
        end
      end
      k++;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] rec);
    lane_valid = v;
    lane_data = d;
    for (int i = 0; i < 4; i++) if (rec[i]) lq[i].push_back(d[i*8 +: 8]);
    tick();
    lane_valid = '0;
  endtask
  task automatic aligned(input string tag);
    drive(4'hF, 32'hA3A2A1A0, 4'hF);
    @(negedge clk); chk({tag, "_pre"}, 32'(valid_out), 0);
    for (int i = 0; i < 4; i++) begin
      tick(); @(negedge clk);
      chk({tag, "_valid"}, 32'(valid_out), 1);
      chk({tag, "_data"}, 32'(data_out), 32'(8'hA0 + i));
    end
    tick(); @(negedge clk); chk({tag, "_end"}, 32'(valid_out), 0);
  endtask
  initial begin
    logic [15:0] w [9];
    logic [31:0] d;
    logic [3:0] v;
    int off [4];
    rst = 1'b1; lane_valid = '0; lane_data = '0; l1_valid = '0; l1_data = '0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_sel", 32'(lane_sel), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_valid1", 32'(v1), 0);
    aligned("al1");
    drive(4'b1011, 32'h13001110, 4'b1011);
    @(negedge clk); chk("sk_pre", 32'(valid_out), 0);
    tick(); @(negedge clk); chk("sk_v0", 32'(valid_out), 1); chk("sk_d0", 32'(data_out), 32'h10);
    tick(); @(negedge clk); chk("sk_d1", 32'(data_out), 32'h11); chk("sk_sel", 32'(lane_sel), 2);
    drive(4'b0100, 32'h00120000, 4'b0100);
    @(negedge clk); chk("sk_wait", 32'(valid_out), 0); chk("sk_wsel", 32'(lane_sel), 2);
    tick(); @(negedge clk); chk("sk_v2", 32'(valid_out), 1); chk("sk_d2", 32'(data_out), 32'h12);
    tick(); @(negedge clk); chk("sk_d3", 32'(data_out), 32'h13);
    tick(); @(negedge clk); chk("sk_end", 32'(valid_out), 0); chk("sk_ovf", 32'(ovf), 0);
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 4; i++) off[i] = int'($urandom_range(0, 3));
      for (int c = 0; c < 4; c++) begin
        v = '0;
        for (int i = 0; i < 4; i++) v[i] = off[i] == c;
        d = $urandom;
        drive(v, d, v);
      end
    end
    repeat (12) tick();
    @(negedge clk);
    chk("rnd_ovf", 32'(ovf), 0);
    chk("rnd_drain", 32'(lq[0].size() + lq[1].size() + lq[2].size() + lq[3].size()), 0);
    chk("rnd_sel", 32'(lane_sel), 0);
    for (int j = 0; j < 6; j++) begin
      d = '0;
      d[15:8] = 8'(8'h50 + j);
      drive(4'b0010, d, j < 4 ? 4'b0010 : 4'b0000);
      @(negedge clk); chk("of_valid", 32'(valid_out), 0);
    end
    chk("of_flag", 32'(ovf), 32'b0010);
    tick(); tick(); @(negedge clk); chk("of_sticky", 32'(ovf), 32'b0010);
    drive(4'b0001, 32'h40, 4'b0001);
    @(negedge clk); chk("of_pre", 32'(valid_out), 0);
    tick(); @(negedge clk); chk("of_d40", 32'(data_out), 32'h40);
    tick(); @(negedge clk); chk("of_d50", 32'(data_out), 32'h50);
    tick(); @(negedge clk); chk("of_wait", 32'(valid_out), 0); chk("of_sel", 32'(lane_sel), 2);
    rst = 1'b1; lane_valid = 4'hF; lane_data = 32'hDEADBEEF;
    tick();
    rst = 1'b0; lane_valid = '0;
    @(negedge clk);
    chk("mr_data", 32'(data_out), 0);
    chk("mr_valid", 32'(valid_out), 0);
    chk("mr_sel", 32'(lane_sel), 0);
    chk("mr_ovf", 32'(ovf), 0);
    tick(); @(negedge clk); chk("mr_idle", 32'(valid_out), 0);
    aligned("al2");
    for (int n = 0; n < 9; n++) w[n] = 16'($urandom);
    for (int n = 0; n <= 9; n++) begin
      if (n < 9) begin
        l1_data = '0;
        l1_data[(n % 3)*16 +: 16] = w[n];
        l1_valid = 3'(1 << (n % 3));
      end
      tick();
      l1_valid = '0;
      @(negedge clk);
      chk("wr_valid", 32'(v1), n > 0 ? 1 : 0);
      if (n > 0) chk("wr_data", 32'(out1), 32'(w[n-1]));
      chk("wr_sel", 32'(sel1), 32'(n % 3));
    end
    tick(); @(negedge clk); chk("wr_end", 32'(v1), 0); chk("wr_ovf", 32'(ovf1), 0);
    chk("final_drain", 32'(lq[0].size() + lq[1].size() + lq[2].size() + lq[3].size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/byte_unstriping_n.md
# byte_unstriping_n

Parametrised byte un-striping stage for the receive path of the PCIe lane model. It collects bytes recovered by the per-lane serial-to-parallel converters and merges them into one ordered byte stream, lane 0 first. Per-lane FIFOs absorb inter-lane skew, and a round-robin pointer restores the original striping order. It feeds the final demux and generalises the fixed 4-lane TX striping to any lane count, data width and skew depth.

## Interface
- NUM_LANES, 4: number of lanes; ≥2.
- DATA_WIDTH, 8: bits per lane word.
- FIFO_DEPTH, 4: words per lane FIFO; power of two, ≥2.
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high.
- LANE_DATA  in  NUM_LANES*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- LANE_VALID  in  NUM_LANES  lane i word present this cycle.
- DATA_OUT  out  DATA_WIDTH  merged byte, registered.
- VALID_OUT  out  1  DATA_OUT valid this cycle, registered.
- LANE_SEL  out  clog2(NUM_LANES)  lane the round-robin pointer currently waits on.
- OVERFLOW  out  NUM_LANES  sticky per-lane drop flag.

## Operation
- One sync FIFO per lane.
  - Push when LANE_VALID[i] is high and the FIFO is not full.
  - A push into a full FIFO is accepted if the same FIFO pops in the same cycle. Otherwise the word is dropped and OVERFLOW[i] is set.
- OVERFLOW[i] stays set until RESET.
- Round-robin pointer rr (drives LANE_SEL) resets to 0.
- Each cycle:
  - If FIFO[rr] is non-empty: pop it, register the word into DATA_OUT, set VALID_OUT=1, and advance rr (NUM_LANES-1 wraps to 0).
  - If FIFO[rr] is empty: VALID_OUT=0, DATA_OUT holds its last value, rr holds. rr never skips an empty lane, so strict lane order is preserved.
- Other lanes keep filling while rr waits on a late lane; this is the skew absorption.
- FIFO occupancy counter width is clog2(FIFO_DEPTH)+1. Read and write pointers are clog2(FIFO_DEPTH) bits and wrap naturally.
- Synchronous RESET (also when asserted mid-stream):
  - Empties all FIFOs; buffered words are discarded, not flushed.
  - rr=0, DATA_OUT=0, VALID_OUT=0, OVERFLOW=0, LANE_SEL=0.
  - LANE_VALID is ignored during the RESET cycle.

## Timing
- A word sampled at edge k into an empty FIFO with rr on that lane appears on DATA_OUT/VALID_OUT after edge k+1. Minimum latency is 2 edges; there is no combinational path from input to output.
- Peak throughput is one word per cycle. Sustained input must be ≤1 word per cycle summed over all lanes; nominal use is one word per lane every NUM_LANES cycles.
- Tolerated skew: FIFO_DEPTH-1 words between the earliest and the latest lane before overflow.
- Simultaneous push and pop on the same FIFO leaves the count unchanged.
- VALID_OUT can deassert mid-stream only when the awaited lane is empty.

## Structure
- Shared package/header holds the clog2 function and the default constants LANES_DEFAULT=4 and LANE_W_DEFAULT=8. The byte striping stage uses the same package.
- Sub-module lane_fifo: single-clock sync FIFO with push, pop, full and empty, parametrised by DATA_WIDTH and FIFO_DEPTH. It is instantiated NUM_LANES times in a generate loop.
- Top level contains the round-robin pointer, the output register and the OVERFLOW flags.

## Test plan
- Aligned stream, defaults: lanes 0-3 each push one word per cycle for one cycle with 0xA0, 0xA1, 0xA2, 0xA3 -> DATA_OUT = 0xA0, 0xA1, 0xA2, 0xA3 on 4 consecutive cycles starting 2 edges after the push, VALID_OUT high for those 4 cycles only.
- Skew: lane 2 delayed 3 cycles relative to lanes 0, 1, 3 (words 0x10-0x13) -> output 0x10, 0x11, then VALID_OUT=0 with LANE_SEL=2 until lane 2 arrives, then 0x12, 0x13. No OVERFLOW.
- Overflow: FIFO_DEPTH=4; lane 1 pushes 6 words while lane 0 never pushes -> lane 1 keeps the first 4 words, OVERFLOW=4'b0010 (sticky), VALID_OUT stays 0.
- Wrap: NUM_LANES=3, DATA_WIDTH=16; push 9 words round-robin -> 9 outputs in order, LANE_SEL sequence 0,1,2,0,1,2,0,1,2,0.
- Reset mid-operation: assert RESET with 2 words buffered and OVERFLOW set -> next cycle all outputs are 0, and a fresh aligned stream reproduces scenario 1 exactly.
